// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters and the round-robin mux arbiter.
//   req     : request per requester, held for the whole transfer
//   last    : final-beat marker per requester
//   gnt     : one-hot grant (all-zero when idle)
//   sel     : mux select, encoded index of gnt while granted
//   busy    : a grant is active
//   preempt : one-cycle pulse after a grant ended by hold timeout
// slave  = arbiter side, master = requester side.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;

  modport slave (
    input  req,
    input  last,
    output gnt,
    output sel,
    output busy,
    output preempt
  );

  modport master (
    output req,
    output last,
    input  gnt,
    input  sel,
    input  busy,
    input  preempt
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4-bit 4:1 mux.
// Every grant is followed by one idle turnaround cycle; a grant is cut short
// after MAX_HOLD cycles only if another requester is waiting.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : mux4_rr_arbiter_if.slave (req/last in, gnt/sel/busy/preempt out)
// Parameters:
//   MAX_HOLD : max grant length while others wait (2 .. 2**HW-1)
//   HW       : hold counter width
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HW       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  mux4_rr_arbiter_if.slave      bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t          state, state_n;
  logic [3:0]      gnt_q, gnt_n;
  logic [1:0]      sel_q, sel_n;
  logic [1:0]      ptr_q, ptr_n;
  logic [HW-1:0]   cnt_q, cnt_n;
  logic            pre_q, pre_n;

  logic            found;
  logic [1:0]      winner;
  logic [1:0]      idx;
  logic            ab, done, others, tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      pre_q <= 1'b0;
    end else begin
      state <= state_n;
      gnt_q <= gnt_n;
      sel_q <= sel_n;
      ptr_q <= ptr_n;
      cnt_q <= cnt_n;
      pre_q <= pre_n;
    end
  end

  // Rotating priority scan starting at ptr.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = '0;
    sel_n   = sel_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    pre_n   = 1'b0;
    ab      = 1'b0;
    done    = 1'b0;
    others  = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_n   = 4'b0001 << winner;
          sel_n   = winner;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        ab     = !bus.req[sel_q];
        done   = bus.req[sel_q] && bus.last[sel_q];
        others = |(bus.req & ~gnt_q);
        tmo    = (cnt_q == HOLD_LAST) && others;
        if (ab || done || tmo) begin
          state_n = IDLE;
          ptr_n   = sel_q + 2'd1;
          // Only a pure timeout is reported; last coinciding with the
          // timeout is an ordinary completion.
          pre_n   = tmo && !ab && !done;
        end else begin
          gnt_n = gnt_q;
          // Saturate so a lone requester keeps its grant indefinitely and
          // is released the first cycle anyone else asks.
          if (cnt_q != HOLD_LAST) cnt_n = cnt_q + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = |gnt_q;
  assign bus.preempt = pre_q;

endmodule
